colocar_bombas_param: RTL and testbench



---
 rtl/buscaminas_pkg.sv | 23 ++
 rtl/detector_flanco.sv | 33 +++
 rtl/colocar_bombas_param.sv | 159 +++++++++++++++
 tb/tb_colocar_bombas_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the minesweeper game blocks.
package buscaminas_pkg;

  localparam int unsigned FILAS_DEF      = 8;
  localparam int unsigned COLS_DEF       = 8;
  localparam int unsigned MAX_BOMBAS_DEF = 10;
  localparam int unsigned LFSR_W         = 16;

  // Feedback taps 16,14,13,11 (bits 15,13,12,10) of a maximal-length Fibonacci LFSR
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    ALEATORIO = 2'd1,
    HECHO     = 2'd2
  } estado_t;

  // One LFSR step: shift left, feedback enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_siguiente(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/detector_flanco.sv
// Push-button synchroniser with rising-edge detection.
// After reset the button must be seen released before any edge counts,
// so a button held through reset never produces an action.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_i,
  output logic pulso_c_o
);

  logic sinc1_q, sinc2_q, previo_q, muestreado_q, armado_q;

  // Two-flop synchroniser, edge register and release-arming flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q      <= 1'b0;
      sinc2_q      <= 1'b0;
      previo_q     <= 1'b0;
      muestreado_q <= 1'b0;
      armado_q     <= 1'b0;
    end else begin
      sinc1_q      <= boton_i;
      sinc2_q      <= sinc1_q;
      previo_q     <= sinc2_q;
      muestreado_q <= 1'b1;
      armado_q     <= armado_q | (muestreado_q & ~sinc1_q);
    end
  end

  // Single-cycle pulse on a synchronised rising edge
  assign pulso_c_o = sinc2_q & ~previo_q & armado_q;

endmodule

// File: rtl/colocar_bombas_param.sv
// Bomb placement: manual place/remove via push-button and LFSR-driven random fill.
module colocar_bombas_param
  import buscaminas_pkg::*;
#(
  parameter int unsigned        FILAS        = FILAS_DEF,
  parameter int unsigned        COLS         = COLS_DEF,
  parameter int unsigned        MAX_BOMBAS   = MAX_BOMBAS_DEF,
  parameter logic [LFSR_W-1:0]  LFSR_SEMILLA = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [$clog2(FILAS)-1:0]            fila,
  input  logic [$clog2(COLS)-1:0]             col,
  input  logic                                button_bomba,
  input  logic                                modo_quitar,
  input  logic                                inicio_aleatorio,
  input  logic [$clog2(MAX_BOMBAS+1)-1:0]     num_bombas,
  output logic [FILAS-1:0][COLS-1:0]          matriz_salida,
  output logic [$clog2(FILAS*COLS+1)-1:0]     cuenta_bombas,
  output logic                                ocupado,
  output logic                                duplicado,
  output logic                                lleno
);

  localparam int unsigned FW = $clog2(FILAS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned NW = $clog2(MAX_BOMBAS + 1);
  localparam int unsigned KW = $clog2(FILAS * COLS + 1);

  estado_t                  estado_q, estado_d;
  logic [FILAS-1:0][COLS-1:0] matriz_q, matriz_d;
  logic [KW-1:0]            cuenta_q, cuenta_d;
  logic [NW-1:0]            objetivo_q, objetivo_d;
  logic                     dup_q, dup_d;
  logic                     lleno_q, lleno_d;
  logic                     ocupado_q, ocupado_d;
  logic [LFSR_W-1:0]        lfsr_q;
  logic                     inicio_prev_q;

  logic                     pulso_boton_c;
  logic                     ini_flanco_c;
  logic                     accion_manual_c;
  logic                     manual_en_rango_c;
  logic [FW-1:0]            cand_fila_c;
  logic [CW-1:0]            cand_col_c;
  logic                     cand_valida_c;
  logic                     objetivo_alcanzado_c;

  detector_flanco u_det_boton (
    .clk       (clk),
    .rst_n     (rst_n),
    .boton_i   (button_bomba),
    .pulso_c_o (pulso_boton_c)
  );

  // Event decoding shared by the FSM and the datapath
  always_comb begin
    ini_flanco_c         = inicio_aleatorio & ~inicio_prev_q & (estado_q == ESPERA);
    accion_manual_c      = pulso_boton_c & ~ini_flanco_c & (estado_q != ALEATORIO);
    manual_en_rango_c    = (32'(fila) < FILAS) && (32'(col) < COLS);
    cand_fila_c          = lfsr_q[FW-1:0];
    cand_col_c           = lfsr_q[FW+CW-1:FW];
    cand_valida_c        = (32'(cand_fila_c) < FILAS) && (32'(cand_col_c) < COLS);
    objetivo_alcanzado_c = (cuenta_q == KW'(objetivo_q));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= ESPERA;
    else        estado_q <= estado_d;
  end

  // FSM next-state logic
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      ESPERA:    if (ini_flanco_c) estado_d = ALEATORIO;
      ALEATORIO: if (objetivo_alcanzado_c) estado_d = HECHO;
      HECHO:     estado_d = ESPERA;
      default:   estado_d = ESPERA;
    endcase
  end

  // FSM outputs and bomb-map datapath next values
  always_comb begin
    matriz_d   = matriz_q;
    cuenta_d   = cuenta_q;
    objetivo_d = objetivo_q;
    dup_d      = 1'b0;
    if (ini_flanco_c) begin
      matriz_d   = '0;
      cuenta_d   = '0;
      objetivo_d = (num_bombas > NW'(MAX_BOMBAS)) ? NW'(MAX_BOMBAS) : num_bombas;
    end else if (estado_q == ALEATORIO) begin
      if (!objetivo_alcanzado_c && cand_valida_c && !matriz_q[cand_fila_c][cand_col_c]) begin
        matriz_d[cand_fila_c][cand_col_c] = 1'b1;
        cuenta_d = cuenta_q + KW'(1);
      end
    end else if (accion_manual_c && manual_en_rango_c) begin
      if (!modo_quitar) begin
        // A full board swallows place requests silently
        if (!lleno_q) begin
          if (matriz_q[fila][col]) begin
            dup_d = 1'b1;
          end else begin
            matriz_d[fila][col] = 1'b1;
            cuenta_d = cuenta_q + KW'(1);
          end
        end
      end else begin
        if (matriz_q[fila][col]) begin
          matriz_d[fila][col] = 1'b0;
          cuenta_d = cuenta_q - KW'(1);
        end else begin
          dup_d = 1'b1;
        end
      end
    end
    lleno_d   = (cuenta_d == KW'(MAX_BOMBAS));
    ocupado_d = (estado_d == ALEATORIO);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matriz_q   <= '0;
      cuenta_q   <= '0;
      objetivo_q <= '0;
      dup_q      <= 1'b0;
      lleno_q    <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      matriz_q   <= matriz_d;
      cuenta_q   <= cuenta_d;
      objetivo_q <= objetivo_d;
      dup_q      <= dup_d;
      lleno_q    <= lleno_d;
      ocupado_q  <= ocupado_d;
    end
  end

  // Free-running LFSR and random-start edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q        <= LFSR_SEMILLA;
      inicio_prev_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_siguiente(lfsr_q);
      inicio_prev_q <= inicio_aleatorio;
    end
  end

  assign matriz_salida = matriz_q;
  assign cuenta_bombas = cuenta_q;
  assign ocupado       = ocupado_q;
  assign duplicado     = dup_q;
  assign lleno         = lleno_q;

endmodule

// File: tb/tb_colocar_bombas_param.sv
// Directed bench for colocar_bombas_param on an 8x8 board with a 10-bomb limit.
module tb_colocar_bombas_param;

  logic             clk;
  logic             rst_n;
  logic [2:0]       fila;
  logic [2:0]       col;
  logic             button_bomba;
  logic             modo_quitar;
  logic             inicio_aleatorio;
  logic [3:0]       num_bombas;
  logic [7:0][7:0]  matriz_salida;
  logic [6:0]       cuenta_bombas;
  logic             ocupado;
  logic             duplicado;
  logic             lleno;

  int               n_cmp;
  int               n_err;
  int               n_dup;
  int               d0;
  logic [63:0]      exp_m;

  colocar_bombas_param #(
    .FILAS        (8),
    .COLS         (8),
    .MAX_BOMBAS   (10),
    .LFSR_SEMILLA (16'hACE1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fila             (fila),
    .col              (col),
    .button_bomba     (button_bomba),
    .modo_quitar      (modo_quitar),
    .inicio_aleatorio (inicio_aleatorio),
    .num_bombas       (num_bombas),
    .matriz_salida    (matriz_salida),
    .cuenta_bombas    (cuenta_bombas),
    .ocupado          (ocupado),
    .duplicado        (duplicado),
    .lleno            (lleno)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which the duplicate pulse is seen
  always @(negedge clk) if (duplicado) n_dup = n_dup + 1;

  task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_cmp = n_cmp + 1;
    if (obs !== esp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
    end
  endtask

  // One button press: hold for several cycles, then release and settle
  task automatic pulsar(input int f, input int c, input logic quitar);
    @(negedge clk);
    fila = 3'(f);
    col = 3'(c);
    modo_quitar = quitar;
    button_bomba = 1'b1;
    repeat (5) @(negedge clk);
    button_bomba = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Launch a random fill, optionally pressing the button meanwhile, and wait for it to end
  task automatic llenar(input int n, input logic con_boton);
    logic fin;
    num_bombas = 4'(n);
    @(negedge clk);
    inicio_aleatorio = 1'b1;
    if (con_boton) begin
      fila = 3'd7;
      col = 3'd7;
      modo_quitar = 1'b0;
      button_bomba = 1'b1;
    end
    @(negedge clk);
    inicio_aleatorio = 1'b0;
    comprobar("fill_ocupado_alto", 64'(ocupado), 64'd1);
    comprobar("fill_cuenta_borrada", 64'(cuenta_bombas), 64'd0);
    fin = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      if (i == 4) button_bomba = 1'b0;
      if (!ocupado) fin = 1'b1;
    end
    button_bomba = 1'b0;
    comprobar("fill_termina", 64'(fin), 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_dup = 0;
    exp_m = '0;
    rst_n = 1'b1;
    button_bomba = 1'b0;
    modo_quitar = 1'b0;
    inicio_aleatorio = 1'b0;
    num_bombas = 4'd0;
    fila = 3'd0;
    col = 3'd0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    comprobar("rst_matriz", 64'(matriz_salida), 64'd0);
    comprobar("rst_cuenta", 64'(cuenta_bombas), 64'd0);
    comprobar("rst_ocupado", 64'(ocupado), 64'd0);
    comprobar("rst_duplicado", 64'(duplicado), 64'd0);
    comprobar("rst_lleno", 64'(lleno), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Three manual placements
    d0 = n_dup;
    pulsar(1, 1, 1'b0); exp_m[1*8+1] = 1'b1;
    pulsar(0, 3, 1'b0); exp_m[0*8+3] = 1'b1;
    pulsar(5, 0, 1'b0); exp_m[5*8+0] = 1'b1;
    comprobar("place3_matriz", 64'(matriz_salida), exp_m);
    comprobar("place3_cuenta", 64'(cuenta_bombas), 64'd3);
    comprobar("place3_sin_dup", 64'(n_dup - d0), 64'd0);

    // Placing on an occupied cell
    d0 = n_dup;
    pulsar(1, 1, 1'b0);
    comprobar("dup_place_matriz", 64'(matriz_salida), exp_m);
    comprobar("dup_place_cuenta", 64'(cuenta_bombas), 64'd3);
    comprobar("dup_place_pulso", 64'(n_dup - d0), 64'd1);

    // Remove, then remove the same empty cell
    pulsar(0, 3, 1'b1); exp_m[0*8+3] = 1'b0;
    comprobar("quitar_matriz", 64'(matriz_salida), exp_m);
    comprobar("quitar_cuenta", 64'(cuenta_bombas), 64'd2);
    d0 = n_dup;
    pulsar(0, 3, 1'b1);
    comprobar("dup_quitar_pulso", 64'(n_dup - d0), 64'd1);
    comprobar("dup_quitar_cuenta", 64'(cuenta_bombas), 64'd2);

    // Fill row 2 to hit the limit, then an 11th placement
    for (int c = 0; c < 8; c++) begin
      pulsar(2, c, 1'b0);
      exp_m[2*8+c] = 1'b1;
    end
    comprobar("lleno_cuenta", 64'(cuenta_bombas), 64'd10);
    comprobar("lleno_flag", 64'(lleno), 64'd1);
    d0 = n_dup;
    pulsar(7, 7, 1'b0);
    comprobar("lleno_11_matriz", 64'(matriz_salida), exp_m);
    comprobar("lleno_11_cuenta", 64'(cuenta_bombas), 64'd10);
    comprobar("lleno_11_sin_dup", 64'(n_dup - d0), 64'd0);

    // Random fill of 7 with a button press landing during the fill
    llenar(7, 1'b1);
    comprobar("rand7_cuenta", 64'(cuenta_bombas), 64'd7);
    comprobar("rand7_popcount", 64'($countones(matriz_salida)), 64'd7);
    comprobar("rand7_lleno", 64'(lleno), 64'd0);
    repeat (20) @(negedge clk);
    comprobar("rand7_estable", 64'(cuenta_bombas), 64'd7);
    comprobar("rand7_ocupado_bajo", 64'(ocupado), 64'd0);

    // Target above the limit is clamped
    llenar(15, 1'b0);
    comprobar("rand15_cuenta", 64'(cuenta_bombas), 64'd10);
    comprobar("rand15_popcount", 64'($countones(matriz_salida)), 64'd10);
    comprobar("rand15_lleno", 64'(lleno), 64'd1);

    // Zero target finishes immediately with an empty board
    llenar(0, 1'b0);
    comprobar("rand0_cuenta", 64'(cuenta_bombas), 64'd0);
    comprobar("rand0_matriz", 64'(matriz_salida), 64'd0);

    // Reset in the middle of a fill, released with the button held
    num_bombas = 4'd7;
    @(negedge clk);
    inicio_aleatorio = 1'b1;
    @(negedge clk);
    inicio_aleatorio = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    comprobar("midrst_matriz", 64'(matriz_salida), 64'd0);
    comprobar("midrst_cuenta", 64'(cuenta_bombas), 64'd0);
    comprobar("midrst_ocupado", 64'(ocupado), 64'd0);
    comprobar("midrst_duplicado", 64'(duplicado), 64'd0);
    comprobar("midrst_lleno", 64'(lleno), 64'd0);
    fila = 3'd3;
    col = 3'd3;
    modo_quitar = 1'b0;
    button_bomba = 1'b1;
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    comprobar("postrst_matriz", 64'(matriz_salida), 64'd0);
    comprobar("postrst_cuenta", 64'(cuenta_bombas), 64'd0);
    comprobar("postrst_ocupado", 64'(ocupado), 64'd0);
    button_bomba = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
